hilo_unit: RTL and testbench
============================

// Module: hilo_unit
// PURPOSE
// - HI/LO register unit downstream of MUL; owns the MULT/MULTU/MTHI/MTLO datapath of the 54-instr CPU.
// - Registers operands onto MUL inputs, waits MUL_LAT cycles, sign-corrects the unsigned 64b product, writes {HI,LO}.
// - Serves MFHI/MFLO reads; stalls the core while a multiply is in flight.
// PARAMETERS
// - MUL_LAT  default 0  cycles from mul_a/mul_b change to valid mul_z (0 = combinational MUL)
// PORTS
// - clk       in   1   core clock, rising edge
// - reset     in   1   asynchronous, active-low reset (0 = reset)
// - op_valid  in   1   HI/LO-writing instruction present this cycle
// - op        in   3   000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU
// - rs_data   in   32  rs operand
// - rt_data   in   32  rt operand
// - mul_a     out  32  registered operand A to MUL
// - mul_b     out  32  registered operand B to MUL
// - mul_z     in   64  unsigned product mul_a*mul_b from MUL
// - rd_req    in   1   MFHI/MFLO executing
// - rd_sel    in   1   1 = HI, 0 = LO
// - rd_data   out  32  selected HI/LO value, combinational
// - busy      out  1   multiply in flight
// - stall     out  1   hold core pipeline this cycle
// - hi, lo    out  32  architectural HI/LO, registered
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE, hi=lo=0, mul_a=mul_b=0, cnt=0, busy=0, stall=0.
// - FSM IDLE -> WAIT -> IDLE.
// - IDLE, op_valid & op in {MULT,MULTU}: edge E0 latches mul_a=rs, mul_b=rt, sign flag, cnt=MUL_LAT; goes WAIT.
// - WAIT: cnt decrements each edge; at edge where cnt==0, {hi,lo}<=corrected product; back to IDLE.
// - Latency: HI/LO valid (MUL_LAT+1) edges after E0; busy=1 for exactly MUL_LAT+1 cycles.
// - Correction (mod 2^64): MULTU = mul_z; MULT = mul_z - (a[31]?{b,32'b0}:0) - (b[31]?{a,32'b0}:0).
// - IDLE, op_valid & MTHI: hi<=rs next edge; MTLO: lo<=rs; single cycle, busy stays 0.
// - stall = busy & (op_valid | rd_req); a stalled op is not accepted; core re-presents it.
// - rd_data = rd_sel ? hi : lo; no bypass. A read in the write-back cycle stalls, sees the new value next cycle.
// - Op accepted in the cycle busy falls (state IDLE) → normal back-to-back operation.
// - Undefined op codes (110, 111; 100/101 without MADD_EN): ignored, no state change.
// - Reset mid-WAIT: operation abandoned, HI/LO cleared, no write-back after release.
// CONFIGURATION
// - HILO_MADD_EN defined: MADD/MADDU accepted; same FSM and latency.
// - With HILO_MADD_EN: write-back is {hi,lo} <= {hi,lo} + corrected product (mod 2^64); MADD signed, MADDU unsigned.
// - HILO_MADD_EN undefined: op 100/101 ignored; no accumulate adder synthesized.
// TESTING
// - MULTU rs=FFFFFFFF rt=00000002, MUL_LAT=0 -> next cycle hi=00000001 lo=FFFFFFFE.
// - MULT rs=FFFFFFFF rt=00000002 -> hi=FFFFFFFF lo=FFFFFFFE; MULT 80000000*80000000 -> hi=40000000 lo=0.
// - MTHI rs=12345678, then rd_req rd_sel=1 -> rd_data=12345678, stall=0, busy never 1.
// - MUL_LAT=3: MULT 7*6 then rd_req rd_sel=0 -> stall=1 for 4 cycles, then rd_data=0000002A.
// - reset=0 during WAIT of MULTU 3*3 -> hi=lo=0 immediately; after release no write, busy=0.
// - HILO_MADD_EN: hi:lo=0:FFFFFFFF, MADDU 1*1 -> hi=00000001 lo=00000000; MADD FFFFFFFF*1 -> hi=0 lo=FFFFFFFF.

Source files
------------

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Purpose:
//   HI/LO register unit sitting downstream of an external unsigned 32x32
//   multiplier (MUL). Owns the MULT/MULTU/MTHI/MTLO datapath: multiply operands
//   are registered onto mul_a/mul_b, the unit waits MUL_LAT cycles for the
//   product, sign-corrects the unsigned 64-bit result for MULT and writes it
//   into {HI,LO}. MFHI/MFLO reads are served combinationally. The core is
//   stalled while a multiply is in flight and it tries to touch HI/LO.
//
// Optional feature:
//   HILO_MADD_EN -- when defined, op 100 (MADD) and 101 (MADDU) are accepted
//                   and accumulate the corrected product into {HI,LO}. When
//                   undefined those codes are ignored and no adder is built.
//
// Parameters:
//   MUL_LAT    cycles from mul_a/mul_b change to a valid mul_z (0 = comb MUL)
//
// Ports:
//   clk        in   1   core clock, rising edge
//   reset      in   1   asynchronous active-low reset
//   op_valid   in   1   HI/LO-writing instruction present this cycle
//   op         in   3   000 MULT, 001 MULTU, 010 MTHI, 011 MTLO,
//                       100 MADD, 101 MADDU (only with HILO_MADD_EN)
//   rs_data    in   32  rs operand
//   rt_data    in   32  rt operand
//   mul_a      out  32  registered operand A to MUL
//   mul_b      out  32  registered operand B to MUL
//   mul_z      in   64  unsigned product mul_a*mul_b from MUL
//   rd_req     in   1   MFHI/MFLO executing
//   rd_sel     in   1   1 = HI, 0 = LO
//   rd_data    out  32  selected HI/LO value (combinational, no bypass)
//   busy       out  1   multiply in flight
//   stall      out  1   hold the core pipeline this cycle
//   hi, lo     out  32  architectural HI/LO registers
// -----------------------------------------------------------------------------
module hilo_unit #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter wide enough to hold MUL_LAT, never narrower than one bit.
  localparam int unsigned CntW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MUL_LAT);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpMthi  = 3'b010;
  localparam logic [2:0] OpMtlo  = 3'b011;
`ifdef HILO_MADD_EN
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMaddu = 3'b101;
`endif

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e          r_state;
  state_e          w_state_d;
  logic [31:0]     r_mul_a;
  logic [31:0]     r_mul_b;
  logic            r_signed;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
`ifdef HILO_MADD_EN
  logic            r_acc;
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic        w_idle;
  logic        w_is_mul;
  logic        w_start;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_done;
  logic [63:0] w_corr;
  logic [63:0] w_wb;

  assign w_idle = (r_state == StIdle);

  // Ops are only ever taken in IDLE; busy (and thus stall) is confined to
  // WAIT, so a stalled op can never slip in here.
  always_comb begin
    w_is_mul = 1'b0;
    if (op_valid) begin
      unique case (op)
        OpMult, OpMultu: w_is_mul = 1'b1;
`ifdef HILO_MADD_EN
        OpMadd, OpMaddu: w_is_mul = 1'b1;
`endif
        default:         w_is_mul = 1'b0;
      endcase
    end
  end

  assign w_start = w_idle & w_is_mul;
  assign w_mthi  = w_idle & op_valid & (op == OpMthi);
  assign w_mtlo  = w_idle & op_valid & (op == OpMtlo);

  // Final WAIT cycle: the product has been stable on mul_z for a full cycle.
  assign w_done  = (r_state == StWait) & (r_cnt == '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StWait;
      StWait:  if (r_cnt == '0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sign correction
  // Treating a signed operand as unsigned adds 2^32 * other_operand to the
  // product for every negative operand; subtract those terms back out.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_corr = mul_z;
    if (r_signed) begin
      w_corr = mul_z
             - (r_mul_a[31] ? {r_mul_b, 32'h0} : 64'h0)
             - (r_mul_b[31] ? {r_mul_a, 32'h0} : 64'h0);
    end
  end

`ifdef HILO_MADD_EN
  assign w_wb = r_acc ? ({r_hi, r_lo} + w_corr) : w_corr;
`else
  assign w_wb = w_corr;
`endif

  // ---------------------------------------------------------------------------
  // Operand, counter and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mul_a  <= 32'h0;
      r_mul_b  <= 32'h0;
      r_signed <= 1'b0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_mul_a  <= rs_data;
      r_mul_b  <= rt_data;
      // Even codes (MULT, MADD) are the signed variants.
      r_signed <= ~op[0];
      r_cnt    <= CntInit;
    end else if ((r_state == StWait) && (r_cnt != '0)) begin
      r_cnt    <= r_cnt - CntW'(1);
    end
  end

`ifdef HILO_MADD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= 1'b0;
    end else if (w_start) begin
      r_acc <= op[2];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'h0;
      r_lo <= 32'h0;
    end else if (w_done) begin
      r_hi <= w_wb[63:32];
      r_lo <= w_wb[31:0];
    end else if (w_mthi) begin
      r_hi <= rs_data;
    end else if (w_mtlo) begin
      r_lo <= rs_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mul_a   = r_mul_a;
  assign mul_b   = r_mul_b;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign busy    = (r_state == StWait);
  assign stall   = busy & (op_valid | rd_req);
  assign rd_data = rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit. A pipelined multiplier model supplies
// mul_z with the configured latency. Expected HI/LO values come from a
// transaction-level model using plain 64-bit arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  hilo_unit #(.MUL_LAT(Lat)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_z    (mul_z),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  // Multiplier model: unsigned product, valid Lat cycles after operands change.
  logic [63:0] mul_prod;
  assign mul_prod = {32'h0, mul_a} * {32'h0, mul_b};

  if (Lat == 0) begin : g_mul_comb
    assign mul_z = mul_prod;
  end else begin : g_mul_pipe
    logic [63:0] pipe [Lat];
    always @(posedge clk) begin
      pipe[0] <= mul_prod;
      for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[Lat-1];
  end

  // Reference model state and scoreboard counters.
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic bit madd_en();
`ifdef HILO_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_mul_op(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd1) return 1'b1;
    if (madd_en() && (o == 3'd4 || o == 3'd5)) return 1'b1;
    return 1'b0;
  endfunction

  // True product of the operands, signed for even op codes, mod 2^64.
  function automatic logic [63:0] product(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (o[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return 64'(ua * ub);
  endfunction

  // Present one op in IDLE, then follow it to completion, poking the unit with
  // stray reads/ops while busy. rd_always forces a read on every busy cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit rd_always);
    logic [63:0] exp;
    int          cyc;
    int          stl;
    int          s;
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
    rd_req   = 1'b0;
    #1 check("stall_idle", 64'(stall), 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    if (is_mul_op(o)) begin
      check("mul_a", 64'(mul_a), 64'(a));
      check("mul_b", 64'(mul_b), 64'(b));
      cyc = 0;
      stl = 0;
      while (busy && cyc < 20) begin
        cyc++;
        s = rd_always ? 1 : int'($urandom_range(0, 2));
        if (s == 1) begin
          rd_req = 1'b1;
          rd_sel = 1'($urandom_range(0, 1));
        end else if (s == 2) begin
          op_valid = 1'b1;
          op       = 3'($urandom_range(0, 7));
          rs_data  = $urandom;
          rt_data  = $urandom;
        end
        #1;
        if (s != 0) begin
          check("stall_busy", 64'(stall), 64'd1);
          if (stall) stl++;
        end
        if (s == 1) check("rd_no_bypass", 64'(rd_data), 64'(rd_sel ? m_hi : m_lo));
        @(negedge clk);
        op_valid = 1'b0;
        rd_req   = 1'b0;
      end
      check("busy_cycles", 64'(cyc), 64'(Lat + 1));
      if (rd_always) check("stall_cycles", 64'(stl), 64'(Lat + 1));
      exp = product(o, a, b);
      if (o[2]) exp = exp + {m_hi, m_lo};
      {m_hi, m_lo} = exp;
    end else begin
      check("busy_never", 64'(busy), 64'd0);
      if (o == 3'd2) m_hi = a;
      if (o == 3'd3) m_lo = a;
    end
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic read_check(input logic sel);
    @(negedge clk);
    rd_req = 1'b1;
    rd_sel = sel;
    #1;
    check("rd_data", 64'(rd_data), 64'(sel ? m_hi : m_lo));
    check("rd_stall", 64'(stall), 64'd0);
    rd_req = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    int unsigned k;
    k = $urandom_range(0, 7);
    case (k)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    op_valid = 1'b0;
    op       = 3'd0;
    rs_data  = 32'h0;
    rt_data  = 32'h0;
    rd_req   = 1'b1;
    rd_sel   = 1'b0;
    m_hi     = 32'h0;
    m_lo     = 32'h0;

    // Reset state.
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("multu_hi", 64'(hi), 64'h0000_0001);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mult_min_hi", 64'(hi), 64'h4000_0000);
    check("mult_min_lo", 64'(lo), 64'h0000_0000);
    issue(3'd2, 32'h1234_5678, 32'h0, 1'b0);
    read_check(1'b1);
    check("mthi_rd", 64'(rd_data), 64'h1234_5678);
    issue(3'd0, 32'd7, 32'd6, 1'b1);
    read_check(1'b0);
    check("mult76_rd", 64'(rd_data), 64'h0000_002A);

    // Undefined codes leave state untouched.
    issue(3'd6, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    issue(3'd7, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0);

    // Accumulate codes (ignored unless the feature is built in).
    issue(3'd2, 32'h0000_0000, 32'h0, 1'b0);
    issue(3'd3, 32'hFFFF_FFFF, 32'h0, 1'b0);
    issue(3'd5, 32'h0000_0001, 32'h0000_0001, 1'b0);
    issue(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
`ifdef HILO_MADD_EN
    check("madd_hi", 64'(hi), 64'h0);
    check("madd_lo", 64'(lo), 64'hFFFF_FFFF);
`else
    check("madd_off_hi", 64'(hi), 64'h0);
    check("madd_off_lo", 64'(lo), 64'hFFFF_FFFF);
`endif

    // Reset while a multiply is waiting.
    issue(3'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    op_valid = 1'b1;
    op       = 3'd1;
    rs_data  = 32'd3;
    rt_data  = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    m_hi = 32'h0;
    m_lo = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (Lat + 3) @(negedge clk);
    check("postrst_busy", 64'(busy), 64'd0);
    check("postrst_hi", 64'(hi), 64'd0);
    check("postrst_lo", 64'(lo), 64'd0);

    // Randomized operation mix.
    for (int n = 0; n < 80; n++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b0);
      if ($urandom_range(0, 2) == 0) read_check(1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
